// File: rtl/dk_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dk_pkg
//  Purpose  : Shared types and constants for the player controllers:
//             jump state encoding, horizontal direction encoding, USB
//             keycodes and a keycode-to-direction helper.
//  Revision : 1.0 - initial release
// ============================================================================
package dk_pkg;

    // Jump sequencer states, explicit 3-bit encoding
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RISE     = 3'd1,
        HANG     = 3'd2,
        FALL     = 3'd3,
        COOLDOWN = 3'd4
    } jump_state_t;

    // Horizontal direction; 2'b11 is never produced
    typedef enum logic [1:0] {
        DIR_NONE  = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_LEFT  = 2'b10
    } dir_t;

    // USB HID keycodes used by the player controllers
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_SPACE = 8'h2C;
    localparam logic [7:0] KEY_NONE  = 8'h00;

    // Map a keycode to a direction. Keys other than A, D or "no key"
    // leave the previously held direction untouched.
    function automatic dir_t key_to_dir(input logic [7:0] key, input dir_t held);
        dir_t d;
        case (key)
            KEY_D:    d = DIR_RIGHT;
            KEY_A:    d = DIR_LEFT;
            KEY_NONE: d = DIR_NONE;
            default:  d = held;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jump_controller_key_edge.sv
`default_nettype none
// ============================================================================
//  Module   : key_edge_detect
//  Purpose  : Rising-edge detector for one keycode. Produces a one-frame
//             pulse on the first frame the keycode equals the match value;
//             holding the key produces no further pulses.
//  Ports    : frame_clk  in   frame clock
//             Reset      in   synchronous active-high reset
//             keycode    in   [7:0] current keycode
//             match      in   [7:0] keycode to watch for
//             pulse      out  high for the first matching frame
//  Revision : 1.0 - initial release
// ============================================================================
module key_edge_detect (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic [7:0] match,
    output logic       pulse
);

    logic w_hit;
    logic r_key_prev;

    assign w_hit = (keycode == match);

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            r_key_prev <= 1'b0;
        end else begin
            r_key_prev <= w_hit;
        end
    end

    // Pulse is combinational so the FSM sees the press on the same edge
    // the key is first sampled.
    assign pulse = w_hit && !r_key_prev;

endmodule
`default_nettype wire

// File: rtl/jump_controller.sv
`default_nettype none
// ============================================================================
//  Module   : jump_controller
//  Purpose  : Frame-rate jump sequencer. On a jump-key press while standing
//             on a floor (and not on a ladder) it runs a RISE/HANG/FALL arc,
//             publishes the height above takeoff and a latched horizontal
//             direction, then holds input locked for a cooldown period.
//  Ports    : frame_clk    in   frame clock
//             Reset        in   synchronous active-high reset
//             keycode      in   [7:0] current USB keycode
//             on_floor     in   player is on a platform row
//             on_ladder    in   player is climbing a ladder
//             jump_active  out  high in RISE, HANG, FALL
//             jump_height  out  [9:0] pixels above takeoff Y
//             jump_dir     out  [1:0] 00 none, 01 right, 10 left
//             input_lock   out  high in RISE, HANG, FALL, COOLDOWN
//  Config   : `define DK_JUMP_BUFFER_EN to remember a press made during
//             COOLDOWN and evaluate it on the first IDLE edge.
//  Revision : 1.0 - initial release
// ============================================================================
module jump_controller
    import dk_pkg::*;
#(
    parameter logic [7:0] JUMP_KEY        = KEY_SPACE,
    parameter int         RISE_STEP       = 2,
    parameter int         RISE_FRAMES     = 8,
    parameter int         HANG_FRAMES     = 4,
    parameter int         COOLDOWN_FRAMES = 6
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic       on_floor,
    input  logic       on_ladder,
    output logic       jump_active,
    output logic [9:0] jump_height,
    output logic [1:0] jump_dir,
    output logic       input_lock
);

    localparam logic [9:0] c_STEP      = 10'(RISE_STEP);
    localparam logic [4:0] c_RISE_LAST = 5'(RISE_FRAMES - 1);
    localparam logic [4:0] c_HANG_LAST = 5'(HANG_FRAMES - 1);
    localparam logic [4:0] c_COOL_LAST = 5'(COOLDOWN_FRAMES - 1);

    jump_state_t r_state;
    logic [9:0]  r_height;
    dir_t        r_jump_dir;
    dir_t        r_last_dir;
    logic [4:0]  r_cnt;

    logic w_press;
    logic w_launch;

    key_edge_detect u_jump_key (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .keycode   (keycode),
        .match     (JUMP_KEY),
        .pulse     (w_press)
    );

`ifdef DK_JUMP_BUFFER_EN
    logic r_buf;
    // A press remembered from COOLDOWN counts like a fresh press in IDLE,
    // still subject to the floor/ladder rules.
    assign w_launch = (w_press || r_buf) && on_floor && !on_ladder;
`else
    assign w_launch = w_press && on_floor && !on_ladder;
`endif

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            r_state    <= IDLE;
            r_height   <= '0;
            r_jump_dir <= DIR_NONE;
            r_last_dir <= DIR_NONE;
            r_cnt      <= '0;
`ifdef DK_JUMP_BUFFER_EN
            r_buf      <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_height   <= '0;
                    r_last_dir <= key_to_dir(keycode, r_last_dir);
`ifdef DK_JUMP_BUFFER_EN
                    r_buf      <= 1'b0;
`endif
                    if (w_launch) begin
                        r_state    <= RISE;
                        r_jump_dir <= r_last_dir;
                        r_cnt      <= '0;
                    end
                end

                RISE: begin
                    r_height <= r_height + c_STEP;
                    if (r_cnt == c_RISE_LAST) begin
                        r_state <= HANG;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end

                HANG: begin
                    if (r_cnt == c_HANG_LAST) begin
                        r_state <= FALL;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end

                FALL: begin
                    // Landing is detected before subtracting so the height
                    // saturates at zero if the step does not divide the peak.
                    if (r_height <= c_STEP) begin
                        r_height   <= '0;
                        r_state    <= COOLDOWN;
                        r_jump_dir <= DIR_NONE;
                        r_cnt      <= '0;
                    end else begin
                        r_height <= r_height - c_STEP;
                    end
                end

                COOLDOWN: begin
                    r_height <= '0;
`ifdef DK_JUMP_BUFFER_EN
                    if (w_press) begin
                        r_buf <= 1'b1;
                    end
`endif
                    if (r_cnt == c_COOL_LAST) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Status flags decode straight from the state register.
    assign jump_active = (r_state == RISE) || (r_state == HANG) || (r_state == FALL);
    assign input_lock  = jump_active || (r_state == COOLDOWN);
    assign jump_height = r_height;
    assign jump_dir    = r_jump_dir;

endmodule
`default_nettype wire

// File: tb/tb_jump_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jump_controller
//  Purpose  : Self-checking bench for jump_controller. The driver issues
//             one frame of inputs per clock and queues the outputs expected
//             after that edge; a monitor pops and compares on the falling
//             edge.
//  Config   : honours DK_JUMP_BUFFER_EN for the cooldown-press check.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_jump_controller;

    logic       frame_clk = 1'b0;
    logic       Reset     = 1'b0;
    logic [7:0] keycode   = 8'h00;
    logic       on_floor  = 1'b0;
    logic       on_ladder = 1'b0;
    logic       jump_active;
    logic [9:0] jump_height;
    logic [1:0] jump_dir;
    logic       input_lock;

    jump_controller dut (
        .frame_clk   (frame_clk),
        .Reset       (Reset),
        .keycode     (keycode),
        .on_floor    (on_floor),
        .on_ladder   (on_ladder),
        .jump_active (jump_active),
        .jump_height (jump_height),
        .jump_dir    (jump_dir),
        .input_lock  (input_lock)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct {
        logic       act;
        logic [9:0] h;
        logic [1:0] dir;
        logic       lock;
        string      nm;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Monitor: every frame presents a new output set after the edge.
    always @(negedge frame_clk) begin
        if (q.size() > 0) begin
            m_e = q.pop_front();
            n_tests++;
            if (jump_active !== m_e.act || jump_height !== m_e.h ||
                jump_dir !== m_e.dir || input_lock !== m_e.lock) begin
                n_fail++;
                $display("FAIL %s: got act=%0b h=%0d dir=%b lock=%0b, want act=%0b h=%0d dir=%b lock=%0b",
                         m_e.nm, jump_active, jump_height, jump_dir, input_lock,
                         m_e.act, m_e.h, m_e.dir, m_e.lock);
            end
        end
    end

    task automatic step(input logic [7:0] kc, input logic fl, input logic ld, input logic rs,
                        input logic e_act, input logic [9:0] e_h, input logic [1:0] e_dir,
                        input logic e_lock, input string nm);
        exp_t e;
        keycode   = kc;
        on_floor  = fl;
        on_ladder = ld;
        Reset     = rs;
        @(posedge frame_clk);
        e.act  = e_act;
        e.h    = e_h;
        e.dir  = e_dir;
        e.lock = e_lock;
        e.nm   = nm;
        q.push_back(e);
        #1;
    endtask

    task automatic idle(input logic [7:0] kc, input logic fl, input logic ld, input string nm);
        step(kc, fl, ld, 1'b0, 1'b0, 10'd0, 2'b00, 1'b0, nm);
    endtask

    // Height after edge n+k of a jump pressed at edge n
    function automatic logic [9:0] arc_h(input int k);
        if (k <= 8)  return 10'(2 * k);
        if (k <= 12) return 10'd16;
        if (k <= 20) return 10'(16 - 2 * (k - 12));
        return 10'd0;
    endfunction

    // Frames n+1..n+26 of a jump. Floor/ladder inputs are disturbed mid-air
    // (they must be ignored); an optional jump press lands in cooldown frame 3.
    task automatic fly(input logic [1:0] d, input logic [7:0] kc_early, input logic [7:0] kc_late,
                       input logic cool_press, input string nm);
        logic [7:0] kc;
        for (int k = 1; k <= 26; k++) begin
            kc = (k >= 14) ? kc_late : kc_early;
            if (cool_press && k == 23) kc = 8'h2C;
            step(kc, !(k >= 3 && k <= 6), (k == 10), 1'b0,
                 (k <= 19), arc_h(k), (k <= 19) ? d : 2'b00, (k <= 25),
                 $sformatf("%s k%0d", nm, k));
        end
    endtask

    task automatic do_jump(input logic [1:0] d, input logic [7:0] kc_early, input logic [7:0] kc_late,
                           input logic cool_press, input string nm);
        step(8'h2C, 1'b1, 1'b0, 1'b0, 1'b1, 10'd0, d, 1'b1, {nm, " press"});
        fly(d, kc_early, kc_late, cool_press, nm);
    endtask

    initial begin
        // Reset state
        step(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 2'b00, 1'b0, "reset0");
        step(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 2'b00, 1'b0, "reset1");

        // D then space: rightward jump; A pressed mid-FALL must not change dir
        idle(8'h07, 1'b1, 1'b0, "set_right");
        do_jump(2'b01, 8'h00, 8'h04, 1'b0, "jump1");

        // Space held across a whole jump and beyond: exactly one jump.
        // Direction is still 01 because last_dir is frozen outside IDLE.
        do_jump(2'b01, 8'h2C, 8'h2C, 1'b0, "hold");
        for (int i = 0; i < 13; i++) idle(8'h2C, 1'b1, 1'b0, $sformatf("held i%0d", i));

        // Release, choose left, press again
        idle(8'h00, 1'b1, 1'b0, "release");
        idle(8'h04, 1'b1, 1'b0, "set_left");
        do_jump(2'b10, 8'h00, 8'h00, 1'b0, "repress");

        // Presses that must be discarded
        idle(8'h00, 1'b1, 1'b0, "gap0");
        idle(8'h2C, 1'b1, 1'b1, "on_ladder");
        idle(8'h00, 1'b1, 1'b0, "gap1");
        idle(8'h2C, 1'b0, 1'b0, "in_air");
        idle(8'h00, 1'b1, 1'b0, "gap2");

        // Reset while rising at height 10
        idle(8'h07, 1'b1, 1'b0, "rst_dir");
        step(8'h2C, 1'b1, 1'b0, 1'b0, 1'b1, 10'd0, 2'b01, 1'b1, "rst press");
        for (int k = 1; k <= 5; k++)
            step(8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 10'(2 * k), 2'b01, 1'b1, $sformatf("rst rise k%0d", k));
        step(8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 10'd0, 2'b00, 1'b0, "rst mid");
        idle(8'h00, 1'b1, 1'b0, "after rst");

        // Press during cooldown frame 3
        idle(8'h07, 1'b1, 1'b0, "cool_dir");
        do_jump(2'b01, 8'h00, 8'h00, 1'b1, "cool");
`ifdef DK_JUMP_BUFFER_EN
        step(8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 10'd0, 2'b01, 1'b1, "buffered launch");
        fly(2'b01, 8'h00, 8'h00, 1'b0, "buffered");
`else
        for (int i = 0; i < 3; i++) idle(8'h00, 1'b1, 1'b0, $sformatf("no_buffer i%0d", i));
`endif

        repeat (3) @(negedge frame_clk);
        #1;
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending checks, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jump_controller.md
Name: jump_controller

Overview:
- Frame-rate sequencer for the player jump; sits beside the player movement datapath.
- Watches the keyboard keycode plus the player's floor and ladder status, and runs a rise/hang/fall arc.
- Publishes a height offset, which the player subtracts from its floor Y, and a latched horizontal direction, which the player uses as its X motion while airborne.
- Also blocks ladder and walk input while a jump is in progress.

Parameters:
- JUMP_KEY, 8'h2C, keycode that triggers a jump (space).
- RISE_STEP, 2, pixels added to or removed from height per frame.
- RISE_FRAMES, 8, frames spent in RISE; peak height = RISE_FRAMES*RISE_STEP = 16.
- HANG_FRAMES, 4, frames held at peak.
- COOLDOWN_FRAMES, 6, frames after landing before a new jump is accepted.

Ports:
- frame_clk  in  1  frame clock; all state updates on its posedge.
- Reset  in  1  synchronous, active-high reset.
- keycode  in  8  current USB keycode (8'h04 A, 8'h07 D, 8'h00 none).
- on_floor  in  1  player Y is on a platform row.
- on_ladder  in  1  player is inside a ladder column and climbing.
- jump_active  out  1  high in RISE, HANG and FALL.
- jump_height  out  10  unsigned pixels above takeoff Y.
- jump_dir  out  2  latched direction: 00 none, 01 right, 10 left; 11 never driven.
- input_lock  out  1  high in RISE, HANG, FALL and COOLDOWN; player ignores W/S/A/D while high.

Behaviour:
- Reset (synchronous, active-high; wins over everything): state=IDLE, jump_height=0, jump_dir=00, cnt=0, last_dir=00, key_prev=0. Also clears the buffer flag when JUMP_BUFFER_EN is defined. All outputs 0.
- Reset asserted mid-jump drops height to 0 on the same edge.
- Edge detect: key_prev <= (keycode==JUMP_KEY). A press is (keycode==JUMP_KEY) && !key_prev, so holding the key never re-triggers.
- last_dir updates in IDLE only:
  - keycode 8'h07 -> 01.
  - 8'h04 -> 10.
  - 8'h00 -> 00.
  - any other code holds.
- State IDLE:
  - A press with on_floor=1 and on_ladder=0 goes to RISE. On that edge: jump_dir<=last_dir, cnt<=0, height stays 0.
  - A press with on_floor=0 or on_ladder=1 is discarded.
- State RISE:
  - Each edge: height += RISE_STEP, cnt++.
  - On the edge where cnt==RISE_FRAMES-1: go to HANG, cnt<=0, height reaches peak on that edge.
- State HANG:
  - Height held.
  - After HANG_FRAMES edges, go to FALL with cnt<=0.
- State FALL:
  - Each edge: height -= RISE_STEP.
  - On the edge where height==RISE_STEP (result 0): go to COOLDOWN, jump_dir<=00, cnt<=0.
  - Height never underflows; saturate at 0 if RISE_STEP does not divide the peak.
- State COOLDOWN:
  - Height 0; presses are ignored.
  - After COOLDOWN_FRAMES edges, go to IDLE.
- Latency:
  - The press is sampled at edge n.
  - jump_active is high after edge n.
  - Height is 2 after edge n+1 and 16 after edge n+8.
  - Height is 0 again after edge n+20; this is the last FALL edge and jump_active falls.
  - Back in IDLE after edge n+26.
- Arithmetic: 10-bit unsigned throughout; cnt is 5 bits, sized for max(RISE_FRAMES,HANG_FRAMES,COOLDOWN_FRAMES) ≤ 31.
- on_floor and on_ladder are ignored outside IDLE. A keycode change during flight does not alter jump_dir.

Optional Feature:
- Macro: DK_JUMP_BUFFER_EN.
- Defined: a press seen during COOLDOWN sets a 1-bit buffer flag.
  - On the COOLDOWN->IDLE edge with the flag set, IDLE evaluates the buffered press on the next edge under the normal on_floor/on_ladder rules, then clears the flag.
  - A buffered press with on_floor=0 is discarded.
- Not defined: COOLDOWN presses are dropped; no flag register exists.

Decomposition:
- Shared package dk_pkg holds:
  - enum jump_state_t {IDLE, RISE, HANG, FALL, COOLDOWN}.
  - Key constants KEY_W=8'h1A, KEY_S=8'h16, KEY_A=8'h04, KEY_D=8'h07, KEY_SPACE=8'h2C.
  - dir_t encoding: 00/01/10.
- One natural sub-module: key_edge_detect (keycode, match value, frame_clk, Reset -> pulse). It is reusable by later fire and pause controllers.

Test Plan:
- Reset, then keycode 8'h07 for 1 frame, then 8'h2C with on_floor=1, on_ladder=0:
  - jump_dir=01.
  - Height sequence 2,4,...,16; hold 16 ×4; 14,...,0.
  - jump_active low after edge n+20; input_lock low after n+26.
- Hold 8'h2C for 40 frames: exactly one jump; no retrigger after IDLE until the key is released and pressed again.
- Press with on_ladder=1, or with on_floor=0: state stays IDLE, height 0, jump_active 0.
- Assert Reset when height=10 during RISE: next edge gives height=0, IDLE, jump_dir=00, input_lock=0.
- Press during COOLDOWN frame 3:
  - Without the macro: no jump.
  - With DK_JUMP_BUFFER_EN and on_floor=1: RISE entered one edge after IDLE.
- Change keycode to 8'h04 mid-FALL: jump_dir stays 01; last_dir unchanged until IDLE.
